// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD nibble type, digit limits and validity check for the up/down counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_t;

  function automatic logic bcd_valid(input bcd_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle of the BCD up/down counter; master drives control, slave returns state.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 2
);

  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  err;

  modport master (
    output en, up, load, load_val,
    input  count, tc, err
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc, err
  );

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit: load with invalid-nibble scrub, or step up/down with carry/borrow out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  input  logic up,
  input  logic load,
  input  bcd_t load_nib,
  output bcd_t nib,
  output logic step_out,
  output logic inv
);

  bcd_t nib_reg;
  bcd_t nib_next;

  always_comb begin
    nib_next = nib_reg;
    if (load) begin
      nib_next = bcd_valid(load_nib) ? load_nib : BCD_MIN;
    end else if (step_in) begin
      if (up) begin
        nib_next = (nib_reg == BCD_MAX) ? BCD_MIN : nib_reg + 4'd1;
      end else begin
        nib_next = (nib_reg == BCD_MIN) ? BCD_MAX : nib_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_reg <= BCD_MIN;
    end else begin
      nib_reg <= nib_next;
    end
  end

  // The next digit steps only when this one rolls over in the current direction.
  assign step_out = step_in & (up ? (nib_reg == BCD_MAX) : (nib_reg == BCD_MIN));
  assign inv      = load & ~bcd_valid(load_nib);
  assign nib      = nib_reg;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, terminal-count pulse and sticky invalid-load flag.
// Define BCD_SAT_EN to saturate at all-9s / all-0s instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input logic               clk,
  input logic               rst,
  bcd_updown_counter_if.slave bus
);

  bcd_t                nib [DIGITS];
  logic [DIGITS:0]     step;
  logic [DIGITS-1:0]   inv;
  logic [4*DIGITS-1:0] count_w;
  logic                tc_reg;
  logic                tc_next;
  logic                err_reg;
  logic                err_next;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .step_in  (step[gi]),
        .up       (bus.up),
        .load     (bus.load),
        .load_nib (bus.load_val[4*gi +: 4]),
        .nib      (nib[gi]),
        .step_out (step[gi+1]),
        .inv      (inv[gi])
      );
      assign count_w[4*gi +: 4] = nib[gi];
    end
  endgenerate

`ifdef BCD_SAT_EN
  logic [DIGITS-1:0] at_lim;
  logic              limit;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lim
      assign at_lim[gi] = (nib[gi] == (bus.up ? BCD_MAX : BCD_MIN));
    end
  endgenerate

  assign limit   = &at_lim;
  // Blocking the chain at digit 0 keeps the final carry low, so tc reports the blocked step.
  assign step[0] = bus.en & ~limit;
  assign tc_next = ~bus.load & ((bus.en & limit) | step[DIGITS]);
`else
  assign step[0] = bus.en;
  assign tc_next = ~bus.load & step[DIGITS];
`endif

  assign err_next = err_reg | (|inv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_reg  <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      tc_reg  <= tc_next;
      err_reg <= err_next;
    end
  end

  assign bus.count = count_w;
  assign bus.tc    = tc_reg;
  assign bus.err   = err_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (1-digit and 2-digit instances).
module tb_bcd_updown_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd_updown_counter_if #(.DIGITS(1)) if1 ();
  bcd_updown_counter_if #(.DIGITS(2)) if2 ();

  bcd_updown_counter #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  bcd_updown_counter #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic idle_all();
    if1.en = 0; if1.up = 0; if1.load = 0; if1.load_val = '0;
    if2.en = 0; if2.up = 0; if2.load = 0; if2.load_val = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick();
    chk("reset d1 count", {4'h0, if1.count}, 8'h00);
    chk("reset d1 tc",    {7'h0, if1.tc},    8'h00);
    chk("reset d1 err",   {7'h0, if1.err},   8'h00);
    chk("reset d2 count", if2.count,         8'h00);
    chk("reset d2 tc",    {7'h0, if2.tc},    8'h00);
    chk("reset d2 err",   {7'h0, if2.err},   8'h00);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_c;
    logic       exp_t;
    if1.load = 1; if1.load_val = 4'h9;
    tick();
    chk("d1 load9 count", {4'h0, if1.count}, 8'h09);
    chk("d1 load9 tc",    {7'h0, if1.tc},    8'h00);
    if1.load = 0; if1.en = 1; if1.up = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 9) begin
        exp_c = 4'(9 - k);
        exp_t = 1'b0;
      end else begin
`ifdef BCD_SAT_EN
        exp_c = 4'h0;
`else
        exp_c = 4'h9;
`endif
        exp_t = 1'b1;
      end
      chk($sformatf("d1 down step%0d count", k), {4'h0, if1.count}, {4'h0, exp_c});
      chk($sformatf("d1 down step%0d tc", k),    {7'h0, if1.tc},    {7'h0, exp_t});
    end
    if1.en = 0;
    tick();
    chk("d1 hold tc", {7'h0, if1.tc}, 8'h00);
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_c [3];
    logic       exp_t [3];
`ifdef BCD_SAT_EN
    exp_c = '{8'h99, 8'h99, 8'h99};
    exp_t = '{1'b0, 1'b1, 1'b1};
`else
    exp_c = '{8'h99, 8'h00, 8'h01};
    exp_t = '{1'b0, 1'b1, 1'b0};
`endif
    if2.load = 1; if2.load_val = 8'h98;
    tick();
    chk("d2 load98 count", if2.count, 8'h98);
    if2.load = 0; if2.en = 1; if2.up = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("d2 up step%0d count", k), if2.count, exp_c[k]);
      chk($sformatf("d2 up step%0d tc", k),    {7'h0, if2.tc}, {7'h0, exp_t[k]});
    end
    if2.en = 0;
    tick();
  endtask

  task automatic test_invalid_load();
    if2.load = 1; if2.load_val = 8'h3C;
    tick();
    chk("d2 load3C count", if2.count,      8'h30);
    chk("d2 load3C err",   {7'h0, if2.err}, 8'h01);
    if2.load = 0; if2.en = 1; if2.up = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("d2 err sticky %0d", k), {7'h0, if2.err}, 8'h01);
    end
    chk("d2 count after 20", if2.count, 8'h50);
    if2.en = 0;
    #3 rst = 1'b1;
    #1;
    chk("d2 rst clears err",   {7'h0, if2.err}, 8'h00);
    chk("d2 rst clears count", if2.count,       8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_priority();
    if2.load = 1; if2.en = 1; if2.up = 1; if2.load_val = 8'h42;
    tick();
    chk("d2 load+en count", if2.count,      8'h42);
    chk("d2 load+en tc",    {7'h0, if2.tc}, 8'h00);
    if2.load = 0;
    tick();
    chk("d2 up after load", if2.count, 8'h43);
    if2.up = 0;
    tick();
    chk("d2 dir change", if2.count, 8'h42);
    if2.en = 0;
    tick();
    chk("d2 hold count", if2.count,      8'h42);
    chk("d2 hold tc",    {7'h0, if2.tc}, 8'h00);
    chk("d2 err clean",  {7'h0, if2.err}, 8'h00);
  endtask

  task automatic test_async_reset();
    if1.load = 1; if1.load_val = 4'h0;
    if2.load = 1; if2.load_val = 8'h57;
    tick();
    if1.load = 0; if1.en = 1; if1.up = 0;
    if2.load = 0;
    tick();
    chk("d2 pre-rst count", if2.count,      8'h57);
    chk("d1 pre-rst tc",    {7'h0, if1.tc}, 8'h01);
    if1.en = 0;
    #3 rst = 1'b1;
    #1;
    chk("d2 async rst count", if2.count,            8'h00);
    chk("d2 async rst tc",    {7'h0, if2.tc},       8'h00);
    chk("d1 async rst count", {4'h0, if1.count},    8'h00);
    chk("d1 async rst tc",    {7'h0, if1.tc},       8'h00);
    #1 rst = 1'b0;
    if2.en = 1; if2.up = 1;
    tick();
    chk("d2 resume count", if2.count, 8'h01);
    if2.en = 0;
    tick();
  endtask

`ifdef BCD_SAT_EN
  task automatic test_saturate();
    if2.load = 1; if2.load_val = 8'h00;
    tick();
    if2.load = 0; if2.en = 1; if2.up = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("sat hold%0d count", k), if2.count,      8'h00);
      chk($sformatf("sat hold%0d tc", k),    {7'h0, if2.tc}, 8'h01);
    end
    if2.up = 1;
    tick();
    chk("sat release count", if2.count,      8'h01);
    chk("sat release tc",    {7'h0, if2.tc}, 8'h00);
    if2.en = 0;
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_all();
    test_reset();
    test_down_wrap();
    test_up_wrap();
    test_invalid_load();
    test_load_priority();
    test_async_reset();
`ifdef BCD_SAT_EN
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
